// File: rtl/button_input_conditioner_pkg.sv
// Shared definitions for the push-button conditioner and its consumers.
// Button codes match the PCU button-status CSR encoding.
package button_input_conditioner_pkg;

  localparam int unsigned NUM_BTN = 5;

  // Bit positions inside btn_raw / btn_level
  localparam int unsigned BIT_U = 0;
  localparam int unsigned BIT_D = 1;
  localparam int unsigned BIT_L = 2;
  localparam int unsigned BIT_R = 3;
  localparam int unsigned BIT_C = 4;

  // Button codes shared with the PCU CSR write logic
  localparam logic [31:0] BTN_NONE   = 32'd0;
  localparam logic [31:0] BTN_UP     = 32'd1;
  localparam logic [31:0] BTN_DOWN   = 32'd2;
  localparam logic [31:0] BTN_LEFT   = 32'd3;
  localparam logic [31:0] BTN_RIGHT  = 32'd4;
  localparam logic [31:0] BTN_CENTER = 32'd5;

  // Per-button press/release state
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Priority encoder: up > down > left > right > centre
  function automatic logic [31:0] btn_encode(input logic [NUM_BTN-1:0] p);
    logic [31:0] code;
    code = BTN_NONE;
    if (p[BIT_U])      code = BTN_UP;
    else if (p[BIT_D]) code = BTN_DOWN;
    else if (p[BIT_L]) code = BTN_LEFT;
    else if (p[BIT_R]) code = BTN_RIGHT;
    else if (p[BIT_C]) code = BTN_CENTER;
    return code;
  endfunction

endpackage

// File: rtl/button_input_conditioner_btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter and
// press/release FSM. fire_o is a combinational strobe that is high on the
// cycle whose closing edge enters HELD (or, with BTN_AUTOREPEAT_EN defined,
// on each auto-repeat period while HELD); the top registers it.
module btn_debounce_ch
  import button_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_CYCLES   = 50000000
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic btn_raw_i,
  output logic fire_o,
  output logic level_o
);

  // Reject parameter sets the counter cannot represent
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range for CNT_W");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 1");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q;
  logic       sync2_q;
  btn_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       press_fire;

  // Two-flop synchroniser; only sync2_q is used downstream
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // FSM state and stability counter registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: every disagreeing sample restarts the count, so the counter
  // stops at CNT_LAST and can never wrap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sync2_q) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!sync2_q) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned       REP_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_q;
  logic             rep_fire;

  assign rep_fire = (state_q == ST_HELD) && sync2_q && (rep_q == REP_LAST);

  // Repeat period counter: runs only while HELD stays HELD, clears otherwise
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rep_q <= '0;
    end else if ((state_q == ST_HELD) && sync2_q && (rep_q != REP_LAST)) begin
      rep_q <= rep_q + REP_W'(1);
    end else begin
      rep_q <= '0;
    end
  end
`endif

  // Outputs: fire strobe and debounced level decoded from the state
  always_comb begin
    press_fire = (state_q == ST_PRESS_WAIT) && sync2_q && (cnt_q == CNT_LAST);
    level_o    = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);
`ifdef BTN_AUTOREPEAT_EN
    fire_o     = press_fire || rep_fire;
`else
    fire_o     = press_fire;
`endif
  end

endmodule

// File: rtl/button_input_conditioner.sv
// Conditions the five raw board buttons into single-cycle press pulses and
// a registered CSR-style button code for the PCU.
// Optional build macro: BTN_AUTOREPEAT_EN (periodic re-fire while held).
module button_input_conditioner
  import button_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_CYCLES   = 50000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  btn_raw,
  input  logic        btn_en,
  output logic        butu,
  output logic        butd,
  output logic        butl,
  output logic        butr,
  output logic        butc,
  output logic [31:0] btn_code,
  output logic [4:0]  btn_level
);

  logic [NUM_BTN-1:0] fire;
  logic [NUM_BTN-1:0] pulse_d, pulse_q;
  logic [31:0]        code_d, code_q;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .btn_raw_i (btn_raw[b]),
      .fire_o    (fire[b]),
      .level_o   (btn_level[b])
    );
  end

  // Gate fires with btn_en on the same edge; a gated fire is simply lost
  always_comb begin
    pulse_d = fire & {NUM_BTN{btn_en}};
    code_d  = btn_encode(pulse_d);
  end

  // Pulse and code registers, kept in the same cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pulse_q <= '0;
      code_q  <= BTN_NONE;
    end else begin
      pulse_q <= pulse_d;
      code_q  <= code_d;
    end
  end

  assign butu     = pulse_q[BIT_U];
  assign butd     = pulse_q[BIT_D];
  assign butl     = pulse_q[BIT_L];
  assign butr     = pulse_q[BIT_R];
  assign butc     = pulse_q[BIT_C];
  assign btn_code = code_q;

endmodule
